// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared constants and FSM state encoding for the decoder scan controller.
// The 3-bit select drives a 3-to-8 decoder, so the requester count is fixed at 8.
package decoder_scan_ctrl_pkg;

   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;

   localparam logic [0:0] STATE_IDLE  = 1'b0;
   localparam logic [0:0] STATE_GRANT = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = STATE_IDLE,
      GRANT = STATE_GRANT
   } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_rr_pick.sv
// Rotating-base priority encoder: the first set request at or above base
// (wrapping 7->0) wins.
module rr_pick
   import decoder_scan_ctrl_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   base,
   output logic [SEL_W-1:0]   idx,
   output logic               any
);

   logic [SEL_W-1:0] cand;

   // The candidate index wraps naturally through the 3-bit addition.
   always_comb begin
      idx  = {SEL_W{1'b0}};
      any  = 1'b0;
      cand = base;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = base + SEL_W'(i);
         if (req[cand] && !any) begin
            idx = cand;
            any = 1'b1;
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Round-robin slot arbiter whose select drives a 3-to-8 decoder.
// All outputs are registered; slot_done marks the last cycle of every slot.
module decoder_scan_ctrl
   import decoder_scan_ctrl_pkg::*;
#(
   parameter int SLOT_CYCLES = 4,
   parameter int NUM_REQ     = 8
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [SEL_W-1:0]   sel,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_vld,
   output logic               slot_done
);

   localparam int               CNT_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [SEL_W-1:0]   last;
   logic [SEL_W-1:0]   last_nxt;
   logic [SEL_W-1:0]   sel_nxt;
   logic [SEL_W-1:0]   base;
   logic [SEL_W-1:0]   pick_idx;
   logic               pick_any;
   logic               slot_end;
   logic               vld_nxt;
   logic               done_nxt;
   logic [NUM_REQ-1:0] grant_nxt;

   assign base = last + {{(SEL_W-1){1'b0}}, 1'b1};

   rr_pick u_rr_pick (
      .req  (req),
      .base (base),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // Next-state logic. slot_done is precomputed one edge ahead, so a slot
   // ends at the edge after slot_done is high; release is seen at the edge
   // that opens the cycle it terminates.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      sel_nxt   = sel;
      vld_nxt   = grant_vld;
      grant_nxt = grant;
      done_nxt  = 1'b0;
      case (state)
         IDLE:    slot_end = 1'b1;
         GRANT:   slot_end = slot_done;
         default: slot_end = 1'b1;
      endcase
      if (slot_end) begin
         if (pick_any) begin
            state_nxt = GRANT;
            cnt_nxt   = {CNT_W{1'b0}};
            last_nxt  = pick_idx;
            sel_nxt   = pick_idx;
            vld_nxt   = 1'b1;
            grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            done_nxt  = (CNT_LAST == {CNT_W{1'b0}});
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = {CNT_W{1'b0}};
            vld_nxt   = 1'b0;
            grant_nxt = {NUM_REQ{1'b0}};
            done_nxt  = 1'b0;
         end
      end else begin
         cnt_nxt  = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         done_nxt = (cnt_nxt == CNT_LAST) || !req[sel];
      end
   end

   // State and output registers; reset abandons any slot in progress.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         cnt       <= {CNT_W{1'b0}};
         last      <= {SEL_W{1'b1}};
         sel       <= {SEL_W{1'b0}};
         grant     <= {NUM_REQ{1'b0}};
         grant_vld <= 1'b0;
         slot_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last      <= last_nxt;
         sel       <= sel_nxt;
         grant     <= grant_nxt;
         grant_vld <= vld_nxt;
         slot_done <= done_nxt;
      end
   end

endmodule
